// File: rtl/upload_packer_if.sv
// Byte-stream bundle for the upload packer: handler-side byte input and
// USB-side framed byte output, each with its own handshake.
interface upload_packer_if;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic       upload_ready;
  logic [7:0] usb_upload_data;
  logic       usb_upload_valid;

  // The packer itself: consumes source bytes, produces framed output.
  modport slave (
    input  src_data, src_valid, upload_ready,
    output src_ready, usb_upload_data, usb_upload_valid
  );

  // The surrounding environment: handler source plus USB sink.
  modport master (
    output src_data, src_valid, upload_ready,
    input  src_ready, usb_upload_data, usb_upload_valid
  );
endinterface

// File: rtl/upload_packer.sv
// Buffers upload bytes in a FIFO and emits framed packets:
// AA 44 CMD LENH LENL payload CSUM, on MAX_PAYLOAD fill or idle timeout.
module upload_packer #(
  parameter int         FIFO_DEPTH     = 256,
  parameter int         MAX_PAYLOAD    = 64,
  parameter int         TIMEOUT_CYCLES = 6000,
  parameter logic [7:0] HDR0           = 8'hAA,
  parameter logic [7:0] HDR1           = 8'h44,
  parameter logic [7:0] CMD_ID         = 8'h0B
) (
  input  logic              clk,
  input  logic              rst_n,
  upload_packer_if.slave    bus,
  output logic              busy,
  output logic [15:0]       drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAXP_C   = CW'(MAX_PAYLOAD);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_CMD, S_LENH, S_LENL, S_PAYLOAD, S_CSUM
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [TW-1:0] r_timer;
  logic [15:0]   r_drop;
  state_t        r_state;
  logic [15:0]   r_len, r_remain;
  logic [7:0]    r_csum, r_data;
  logic          r_valid;

  logic [AW-1:0] w_rd_next;
  logic          w_full, w_wr, w_beat, w_rd, w_trigger;
  logic [15:0]   w_len;

  assign w_full    = (r_count == DEPTH_C);
  assign w_wr      = bus.src_valid && !w_full;
  assign w_beat    = r_valid && bus.upload_ready;
  assign w_rd      = (r_state == S_PAYLOAD) && w_beat;
  assign w_rd_next = r_rd_ptr + AW'(1);
  assign w_trigger = (r_count >= MAXP_C) || ((r_count != '0) && (r_timer == TMO_LAST));
  assign w_len     = (r_count >= MAXP_C) ? 16'(MAX_PAYLOAD) : 16'(r_count);

  assign bus.src_ready        = !w_full;
  assign bus.usb_upload_data  = r_data;
  assign bus.usb_upload_valid = r_valid;
  assign busy                 = (r_state != S_IDLE);
  assign drop_cnt             = r_drop;

  // NOTE: the storage array has no reset; emptiness is defined by the pointers
  // and count alone, so clearing those is enough to discard buffered data.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= bus.src_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_timer  <= '0;
      r_drop   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= w_rd_next;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // The timer also restarts when a frame closes, so leftover bytes wait a full timeout.
      if (w_wr || (r_count == '0) || ((r_state == S_CSUM) && w_beat))
        r_timer <= '0;
      else if (r_state == S_IDLE)
        r_timer <= r_timer + TW'(1);
      if (bus.src_valid && w_full && (r_drop != 16'hFFFF))
        r_drop <= r_drop + 16'd1;
    end
  end

  // Payload bytes are fetched one beat ahead so LENL->PAYLOAD and
  // PAYLOAD->PAYLOAD transitions never insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_remain <= '0;
      r_csum   <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_trigger) begin
        r_len   <= w_len;
        r_csum  <= '0;
        r_data  <= HDR0;
        r_valid <= 1'b1;
        r_state <= S_HDR0;
      end
    end else if (w_beat) begin
      case (r_state)
        S_HDR0: begin
          r_data  <= HDR1;
          r_state <= S_HDR1;
        end
        S_HDR1: begin
          r_data  <= CMD_ID;
          r_state <= S_CMD;
        end
        S_CMD: begin
          r_csum  <= r_csum + r_data;
          r_data  <= r_len[15:8];
          r_state <= S_LENH;
        end
        S_LENH: begin
          r_csum  <= r_csum + r_data;
          r_data  <= r_len[7:0];
          r_state <= S_LENL;
        end
        S_LENL: begin
          r_csum   <= r_csum + r_data;
          r_data   <= r_mem[r_rd_ptr];
          r_remain <= r_len;
          r_state  <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          r_csum <= r_csum + r_data;
          if (r_remain == 16'd1) begin
            r_data  <= r_csum + r_data;
            r_state <= S_CSUM;
          end else begin
            r_remain <= r_remain - 16'd1;
            r_data   <= r_mem[w_rd_next];
          end
        end
        default: begin
          r_data  <= '0;
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upload_packer.sv
// Directed bench for upload_packer: timeout and full-frame triggers,
// backpressure, overflow drops, frame splitting and reset mid-frame.
module tb_upload_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  upload_packer_if bus();

  upload_packer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
  int         viol     = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         cyc_q[$];
  int         t0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.upload_ready = 1'b0;
      1:       bus.upload_ready = 1'b1;
      default: bus.upload_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Beats are recorded half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (prev_stall && (!bus.usb_upload_valid || (bus.usb_upload_data !== prev_data)))
      viol++;
    prev_stall = bus.usb_upload_valid && !bus.upload_ready;
    prev_data  = bus.usb_upload_data;
    if (bus.usb_upload_valid && bus.upload_ready) begin
      got_q.push_back(bus.usb_upload_data);
      cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_q.delete();
    cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic write_bytes(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      bus.src_data  = 8'(first + i);
      bus.src_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.src_valid = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int k = 0;
    while ((got_q.size() < n) && (k < budget)) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_arrived"}, 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic add_frame(input int first, input int len);
    logic [7:0] s;
    s = 8'h0B + 8'(len >> 8) + 8'(len);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h0B);
    exp_q.push_back(8'(len >> 8));
    exp_q.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(8'(first + i));
      s = s + 8'(first + i);
    end
    exp_q.push_back(s);
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    bus.src_data     = '0;
    bus.src_valid    = 1'b0;
    bus.upload_ready = 1'b1;

    // Reset state
    idle(3);
    check("rst_valid", 32'(bus.usb_upload_valid), 32'd0);
    check("rst_data",  32'(bus.usb_upload_data),  32'd0);
    check("rst_busy",  32'(busy),                 32'd0);
    check("rst_ready", 32'(bus.src_ready),        32'd1);
    check("rst_drop",  32'(drop_cnt),             32'd0);
    rst_n = 1'b1;
    idle(2);

    // Short frame flushed by timeout, no backpressure
    clear_q();
    write_bytes(1, 3);
    t0 = cyc;
    wait_beats("t1", 9, 7000);
    check("t1_valid_drop", 32'(bus.usb_upload_valid), 32'd0);
    check("t1_busy_drop",  32'(busy),                 32'd0);
    exp_q = {8'hAA, 8'h44, 8'h0B, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h14};
    compare("t1");
    if (got_q.size() >= 9) begin
      check("t1_latency", 32'(cyc_q[0] - t0), 32'd6000);
      check("t1_nobubble", 32'(cyc_q[8] - cyc_q[0]), 32'd8);
    end
    idle(3);

    // Full 64-byte burst triggers without timeout
    clear_q();
    write_bytes(0, 64);
    wait_beats("t2", 70, 300);
    add_frame(0, 64);
    compare("t2");
    if (got_q.size() >= 70) begin
      check("t2_csum", 32'(got_q[69]), 32'h2B);
      check("t2_nobubble", 32'(cyc_q[69] - cyc_q[0]), 32'd69);
    end
    check("t2_valid_drop", 32'(bus.usb_upload_valid), 32'd0);
    idle(3);

    // Random backpressure: same bytes, data held during stalls
    clear_q();
    viol = 0;
    rdy_mode = 2;
    write_bytes(1, 3);
    wait_beats("t3", 9, 8000);
    exp_q = {8'hAA, 8'h44, 8'h0B, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h14};
    compare("t3");
    check("t3_stable", 32'(viol), 32'd0);
    rdy_mode = 1;
    idle(4);

    // Overflow with USB stalled, then drain four full frames
    rdy_mode = 0;
    idle(2);
    clear_q();
    viol = 0;
    write_bytes(0, 257);
    check("t4_src_ready", 32'(bus.src_ready), 32'd0);
    check("t4_drop",      32'(drop_cnt),      32'd1);
    check("t4_busy",      32'(busy),          32'd1);
    check("t4_no_beats",  32'(got_q.size()),  32'd0);
    rdy_mode = 1;
    wait_beats("t4", 280, 1000);
    idle(3);
    for (int f = 0; f < 4; f++) add_frame(f * 64, 64);
    compare("t4");
    check("t4_stable",  32'(viol),           32'd0);
    check("t4_ready_back", 32'(bus.src_ready), 32'd1);
    check("t4_idle",    32'(busy),           32'd0);

    // 100-byte burst: 64-byte frame, then 36-byte frame after timeout
    clear_q();
    write_bytes(0, 100);
    wait_beats("t5", 112, 8000);
    add_frame(0, 64);
    add_frame(64, 36);
    compare("t5");
    idle(3);

    // Reset in the middle of PAYLOAD
    clear_q();
    write_bytes(0, 64);
    wait_beats("t6_pre", 10, 200);
    check("t6_busy_pre", 32'(busy),     32'd1);
    check("t6_drop_pre", 32'(drop_cnt), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(bus.usb_upload_valid), 32'd0);
    check("t6_busy",  32'(busy),                 32'd0);
    check("t6_drop",  32'(drop_cnt),             32'd0);
    check("t6_ready", 32'(bus.src_ready),        32'd1);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    clear_q();
    write_bytes(8'h5A, 1);
    wait_beats("t6", 7, 7000);
    idle(3);
    exp_q = {8'hAA, 8'h44, 8'h0B, 8'h00, 8'h01, 8'h5A, 8'h66};
    compare("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/upload_packer.md
Name: upload_packer

Overview:
- Sits between the `cdc` command-handler upload sources and the `USB_CDC` upload port, in the `PHY_CLK` (60 MHz) domain.
- Buffers raw upload bytes in an internal FIFO and wraps them into framed packets: header, command ID, length, payload and checksum.
- Drives `usb_upload_data` / `usb_upload_valid` with backpressure from the USB side.
- Sends a frame when `MAX_PAYLOAD` bytes are buffered, or when the idle timeout expires with data pending.

Parameters:
- FIFO_DEPTH, 256: payload FIFO depth in bytes; power of 2.
- MAX_PAYLOAD, 64: maximum payload bytes per frame; must be ≤ FIFO_DEPTH.
- TIMEOUT_CYCLES, 6000: idle cycles with non-empty FIFO before a short frame is flushed (100 µs at 60 MHz).
- HDR0, 8'hAA: first header byte.
- HDR1, 8'h44: second header byte.
- CMD_ID, 8'h0B: command/type byte placed in every frame.

Ports:
- clk  input  1  system clock (`PHY_CLK`).
- rst_n  input  1  asynchronous, active-low reset.
- src_data  input  8  upload byte from handler.
- src_valid  input  1  src_data valid this cycle.
- src_ready  output  1  FIFO can accept a byte.
- upload_ready  input  1  USB side accepts the current output byte; tie to 1 if there is no backpressure.
- usb_upload_data  output  8  framed byte to `USB_CDC`.
- usb_upload_valid  output  1  usb_upload_data valid.
- busy  output  1  a frame is in progress (state ≠ IDLE).
- drop_cnt  output  16  count of bytes lost to FIFO-full; saturating.

Behaviour:
- Reset (async assert, sync release):
  - FIFO emptied, state = IDLE, timer = 0, drop_cnt = 0.
  - usb_upload_valid = 0, usb_upload_data = 0, busy = 0.
  - src_ready = 1.
- Input side:
  - src_ready = !fifo_full.
  - A write occurs when src_valid && src_ready.
  - When src_valid && !src_ready, the byte is lost and drop_cnt increments, saturating at 16'hFFFF.
- FIFO occupancy:
  - A simultaneous write and payload read leave the count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - A write to an empty FIFO in the same cycle as a read attempt is not readable in that cycle.
- Timer:
  - Cleared on every write and whenever the FIFO is empty.
  - Otherwise increments in IDLE; holds outside IDLE.
- Trigger (IDLE only):
  - Fires if count ≥ MAX_PAYLOAD, or if count > 0 and timer == TIMEOUT_CYCLES−1.
  - On trigger, latch LEN = min(count, MAX_PAYLOAD) as 16 bits and go to HDR0.
  - usb_upload_valid rises with HDR0 on the next cycle.
- State sequence: IDLE → HDR0 → HDR1 → CMD → LENH → LENL → PAYLOAD (LEN beats) → CSUM → IDLE.
- Output handshake:
  - Each state presents one byte with usb_upload_valid = 1.
  - The beat completes on a rising clk where valid && upload_ready.
  - Data must stay stable and valid must stay high until the beat completes.
  - With upload_ready held at 1, one byte is emitted per cycle with no bubbles, including the LENL→PAYLOAD transition. The implementation prefetches from the FIFO to guarantee this.
- Length bytes: LENH = LEN[15:8], LENL = LEN[7:0].
- Payload: FIFO bytes in write order; exactly LEN bytes are popped, one per completed PAYLOAD beat.
- Checksum:
  - CSUM = (CMD_ID + LENH + LENL + Σ payload) mod 256.
  - Accumulated only on completed beats; HDR0 and HDR1 are excluded.
- After the CSUM beat completes:
  - Return to IDLE with usb_upload_valid = 0 for at least one cycle.
  - Re-evaluate the trigger from IDLE; the timer restarts from 0.
- During a frame, writes continue to fill the FIFO. Bytes beyond LEN go into the next frame.
- Reset mid-frame: the frame is abandoned immediately, valid drops asynchronously, and buffered data is discarded.
- busy = 1 in every state except IDLE.

Test Plan:
- Write 0x01, 0x02, 0x03 and then idle, upload_ready = 1 → after 6000 idle cycles, the stream is AA 44 0B 00 03 01 02 03 14 on consecutive cycles, then valid = 0.
- Burst 64 bytes 0x00..0x3F back-to-back → frame issued without waiting for the timeout: AA 44 0B 00 40, then 00..3F, then CSUM = (0x0B + 0x40 + 0x7E0) mod 256 = 0x2B.
- Repeat the 3-byte case while toggling upload_ready with a random 50% duty → identical byte sequence; data stable while valid && !ready; no byte duplicated or skipped.
- Hold upload_ready = 0 and write 257 bytes → src_ready falls after byte 256 and drop_cnt = 1. Then release ready → four 64-byte frames drain the FIFO.
- Write 100 bytes in a burst → a frame of LEN 0x0040; the remaining 36 bytes go out in a second frame of LEN 0x0024 after the timeout. Bytes written during the first frame appear in order in the second.
- Assert rst_n = 0 during the PAYLOAD state → usb_upload_valid = 0, busy = 0, drop_cnt = 0, FIFO empty. After release, a new 1-byte write yields AA 44 0B 00 01 xx with the correct checksum.
